// File: rtl/alu_result_writeback.sv
// Consumer end of the ALU result interface: updates Z/V/N flags in accept order and
// buffers {dst, data} in a small FIFO that drains to the register-file write port.
module alu_result_writeback #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4,
  parameter int RA_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     res_valid,
  output logic                     res_ready,
  input  logic [DATA_W-1:0]        res_data,
  input  logic                     res_ovfl,
  input  logic [1:0]               res_opcode,
  input  logic [RA_W-1:0]          res_dst,
  output logic                     wr_en,
  input  logic                     wr_ready,
  output logic [RA_W-1:0]          wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic                     flag_z,
  output logic                     flag_v,
  output logic                     flag_n,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = RA_W + DATA_W;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // ready never depends combinationally on valid on either side.

  logic [ENT_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [RA_W-1:0]   last_addr;
  logic [DATA_W-1:0] last_data;
  logic [RA_W-1:0]   head_dst;
  logic [DATA_W-1:0] head_data;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign res_ready = !full;
  assign push      = res_valid && res_ready;
  assign {head_dst, head_data} = mem[rd_ptr];

  // R0 is hardwired zero: such entries leave the FIFO without a write strobe.
  assign wr_en   = !empty && (head_dst != '0);
  assign pop     = !empty && ((head_dst == '0) || wr_ready);
  assign wr_addr = empty ? last_addr : head_dst;
  assign wr_data = empty ? last_data : head_data;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {res_dst, res_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      last_addr <= '0;
      last_data <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        last_addr <= head_dst;
        last_data <= head_data;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Logic opcodes (NAND/XOR, opcode[1]=1) only affect Z; V and N keep the last arithmetic result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
      flag_v <= 1'b0;
      flag_n <= 1'b0;
    end else if (push) begin
      flag_z <= (res_data == '0);
      if (!res_opcode[1]) begin
        flag_v <= res_ovfl;
        flag_n <= res_data[DATA_W-1];
      end
    end
  end

endmodule
